// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Purpose : Groups the bus signals around the shared ALU arbiter. These are
//           the two requester channels, the ALU drive and return path, and
//           the tagged response channel.
// Modports:
//   slave  - the arbiter. It receives requests and ALU outputs, and drives
//            the ALU inputs, the response channel and busy.
//   master - the environment: requesters, ALU instance and response consumer.
// Signals :
//   reqN_valid/ready/a/b/ctrl  requester N operation handshake (N = 0, 1)
//   alu_a/alu_b/alu_control    drive into the combinational ALU
//   alu_result/zero/neg        ALU outputs
//   rsp_valid/ready/id/result/zero/neg  response channel tagged by requester
//   busy                       arbiter is not idle
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int LENGTH = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [LENGTH-1:0] req0_a;
    logic [LENGTH-1:0] req0_b;
    logic [3:0]        req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [LENGTH-1:0] req1_a;
    logic [LENGTH-1:0] req1_b;
    logic [3:0]        req1_ctrl;

    logic [LENGTH-1:0] alu_a;
    logic [LENGTH-1:0] alu_b;
    logic [3:0]        alu_control;
    logic [LENGTH-1:0] alu_result;
    logic              alu_zero;
    logic              alu_neg;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [LENGTH-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_neg;

    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  alu_result, alu_zero, alu_neg,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_control,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_neg,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output alu_result, alu_zero, alu_neg,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_control,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_neg,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Purpose : Time-shares one combinational ALU between two requesters. It
//           accepts one operation at a time (round-robin when both ask),
//           drives the ALU for one cycle and returns the captured result and
//           flags on a response channel tagged with the requester ID.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   arb  - alu_share_arbiter_if.slave bundle (requests, ALU, response, busy)
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int LENGTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  arb
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unused control code: the ALU outputs 0 for it, so the ALU stays quiet
    // between operations.
    localparam logic [3:0] CTRL_NOP = 4'b1111;

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [LENGTH-1:0] alu_a_q,      alu_a_d;
    logic [LENGTH-1:0] alu_b_q,      alu_b_d;
    logic [3:0]        alu_ctrl_q,   alu_ctrl_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic              rsp_id_q,     rsp_id_d;
    logic [LENGTH-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q,   rsp_zero_d;
    logic              rsp_neg_q,    rsp_neg_d;

    logic              grant_vld;
    logic              grant_id;

    // Arbitration only happens in IDLE. When both requesters ask, the one
    // that was not served last wins, so a waiting requester is served at the
    // next grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE) begin
            if (arb.req0_valid && arb.req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (arb.req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (arb.req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    // Next-state and datapath next values. Every register holds by default.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d      = EXEC;
                    last_grant_d = grant_id;
                    rsp_id_d     = grant_id;
                    alu_a_d      = grant_id ? arb.req1_a    : arb.req0_a;
                    alu_b_d      = grant_id ? arb.req1_b    : arb.req0_b;
                    alu_ctrl_d   = grant_id ? arb.req1_ctrl : arb.req0_ctrl;
                end
            end
            EXEC: begin
                // The ALU has had a full cycle to settle on the latched operands.
                rsp_result_d = arb.alu_result;
                rsp_zero_d   = arb.alu_zero;
                rsp_neg_d    = arb.alu_neg;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_valid_q && arb.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    alu_ctrl_d  = CTRL_NOP;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;   // port 0 wins the first contested grant
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= CTRL_NOP;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
        end
    end

    assign arb.req0_ready  = grant_vld && !grant_id;
    assign arb.req1_ready  = grant_vld &&  grant_id;
    assign arb.alu_a       = alu_a_q;
    assign arb.alu_b       = alu_b_q;
    assign arb.alu_control = alu_ctrl_q;
    assign arb.rsp_valid   = rsp_valid_q;
    assign arb.rsp_id      = rsp_id_q;
    assign arb.rsp_result  = rsp_result_q;
    assign arb.rsp_zero    = rsp_zero_q;
    assign arb.rsp_neg     = rsp_neg_q;
    assign arb.busy        = (state_q != IDLE);
endmodule
